// File: rtl/motion_vectors_decoder.sv
// -----------------------------------------------------------------------------
// motion_vectors_decoder
//
// Sequential parser for one MPEG-2 motion_vectors() set (s=0, one vector,
// field mv_format, full_pel_vector=0). A start request snapshots the bitstream
// window and the prediction state. The FSM then walks the field-select,
// horizontal and vertical motion_code / motion_residual / dmvector fields,
// taking one cycle per field. It presents the updated PMV / field-select
// arrays with a sticky done flag.
//
// Ports
//   clk                     clock, rising edge
//   rst                     asynchronous reset, active low
//   in_valid                start request, sampled only while idle
//   in_PMV_r_s_t  (x8)      signed prediction vectors [r][s][h=0/v=1]
//   in_mvfs_r_s   (x4)      motion_vertical_field_select[r][s]
//   dmv                     dual-prime flag (nonzero = true)
//   mvscale                 vertical scale flag (nonzero = true)
//   in_bfr                  bitstream window, bit 16383 is the first bit
//   out_PMV_r_s_t (x8)      updated prediction vectors
//   out_mvfs_r_s  (x4)      updated field selects
//   out_dmvector_0/1        dual-prime differential (h, v), -1/0/+1
//   done                    results valid, held until reset
//
// state   | meaning
// IDLE    | wait for in_valid, snapshot inputs
// FSEL    | field-select bit (only when dmv==0)
// HCODE   | horizontal motion_code VLC + sign
// HRES    | horizontal residual, horizontal vector update
// HDMV    | horizontal dmvector (only when dmv!=0)
// VCODE   | vertical motion_code VLC + sign
// VRES    | vertical residual, vertical vector update
// VDMV    | vertical dmvector (only when dmv!=0)
// DONE    | load outputs, raise done
// HOLD    | results held, in_valid ignored
// -----------------------------------------------------------------------------
module motion_vectors_decoder #(
  parameter int H_R_SIZE = 8,
  parameter int V_R_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [31:0] in_PMV_0_0_0,
  input  logic signed [31:0] in_PMV_0_0_1,
  input  logic signed [31:0] in_PMV_0_1_0,
  input  logic signed [31:0] in_PMV_0_1_1,
  input  logic signed [31:0] in_PMV_1_0_0,
  input  logic signed [31:0] in_PMV_1_0_1,
  input  logic signed [31:0] in_PMV_1_1_0,
  input  logic signed [31:0] in_PMV_1_1_1,
  input  logic [31:0]        in_mvfs_0_0,
  input  logic [31:0]        in_mvfs_0_1,
  input  logic [31:0]        in_mvfs_1_0,
  input  logic [31:0]        in_mvfs_1_1,
  input  logic [31:0]        dmv,
  input  logic [31:0]        mvscale,
  input  logic [16383:0]     in_bfr,
  output logic signed [31:0] out_PMV_0_0_0,
  output logic signed [31:0] out_PMV_0_0_1,
  output logic signed [31:0] out_PMV_0_1_0,
  output logic signed [31:0] out_PMV_0_1_1,
  output logic signed [31:0] out_PMV_1_0_0,
  output logic signed [31:0] out_PMV_1_0_1,
  output logic signed [31:0] out_PMV_1_1_0,
  output logic signed [31:0] out_PMV_1_1_1,
  output logic [31:0]        out_mvfs_0_0,
  output logic [31:0]        out_mvfs_0_1,
  output logic [31:0]        out_mvfs_1_0,
  output logic [31:0]        out_mvfs_1_1,
  output logic signed [31:0] out_dmvector_0,
  output logic signed [31:0] out_dmvector_1,
  output logic               done
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FSEL  = 4'd1;
  localparam logic [3:0] S_HCODE = 4'd2;
  localparam logic [3:0] S_HRES  = 4'd3;
  localparam logic [3:0] S_HDMV  = 4'd4;
  localparam logic [3:0] S_VCODE = 4'd5;
  localparam logic [3:0] S_VRES  = 4'd6;
  localparam logic [3:0] S_VDMV  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_HOLD  = 4'd9;

  // Top r_size bits of the window, MSB first.
  function automatic logic [31:0] f_residual(input logic [15:0] win, input int rsize);
    logic [31:0] wide;
    wide = {16'd0, win};
    if (rsize == 0) return 32'd0;
    return wide >> (16 - rsize);
  endfunction

  // Apply a decoded motion_code/residual to a prediction and wrap into
  // [-lim, lim).
  function automatic logic signed [31:0] f_decode(input logic signed [31:0] vec,
                                                  input logic [4:0]         mag,
                                                  input logic               neg,
                                                  input logic [31:0]        res,
                                                  input int                 rsize);
    logic signed [31:0] lim;
    logic signed [31:0] delta;
    logic signed [31:0] sum;
    lim   = 32'sd16 <<< rsize;
    delta = $signed(((32'(mag) - 32'd1) << rsize) + res + 32'd1);
    sum   = vec;
    if (mag != 5'd0) begin
      if (!neg) begin
        sum = vec + delta;
        if (sum >= lim) sum = sum - (lim <<< 1);
      end else begin
        sum = vec - delta;
        if (sum < -lim) sum = sum + (lim <<< 1);
      end
    end
    return sum;
  endfunction

  logic [3:0]         r_state;
  logic [13:0]        r_ptr;
  logic [16383:0]     r_bfr;
  logic               r_dmv;
  logic               r_mvscale;
  logic signed [31:0] r_pmv000;
  logic signed [31:0] r_pmv001;
  logic signed [31:0] r_pmv010;
  logic signed [31:0] r_pmv011;
  logic signed [31:0] r_pmv110;
  logic signed [31:0] r_pmv111;
  logic [31:0]        r_mvfs00;
  logic [31:0]        r_mvfs01;
  logic [31:0]        r_mvfs10;
  logic [31:0]        r_mvfs11;
  logic [4:0]         r_mag;
  logic               r_neg;
  logic signed [31:0] r_dmv_h;
  logic signed [31:0] r_dmv_v;

  // PMV[1][0] inputs are always overwritten by the new PMV[0][0].
  logic w_unused_pmv10;
  assign w_unused_pmv10 = ^{in_PMV_1_0_0, in_PMV_1_0_1};

  // 16-bit look-ahead window starting at the bit pointer; the longest field
  // (1 + 9 + sign, or a 14-bit residual) always fits.
  logic [13:0] w_base;
  logic [15:0] w_win;
  assign w_base = 14'd16383 - r_ptr;
  assign w_win  = r_bfr[w_base -: 16];

  // motion_code VLC: leading '1' is code 0; otherwise classify the next
  // 9 bits by range to find the codeword length and magnitude.
  logic [8:0] w_peek;
  logic [4:0] w_mag;
  logic [3:0] w_vlc_len;
  logic       w_neg;
  logic [3:0] w_code_len;

  always_comb begin
    w_peek     = w_win[14:6];
    w_mag      = 5'd0;
    w_vlc_len  = 4'd0;
    w_neg      = 1'b0;
    w_code_len = 4'd1;
    if (!w_win[15]) begin
      if (w_peek >= 9'd64) begin
        case (w_peek[8:6])
          3'd1:       begin w_mag = 5'd3; w_vlc_len = 4'd3; end
          3'd2, 3'd3: begin w_mag = 5'd2; w_vlc_len = 4'd2; end
          default:    begin w_mag = 5'd1; w_vlc_len = 4'd1; end
        endcase
      end else if (w_peek >= 9'd24) begin
        case (w_peek[5:3])
          3'd3:    begin w_mag = 5'd7; w_vlc_len = 4'd6; end
          3'd4:    begin w_mag = 5'd6; w_vlc_len = 4'd6; end
          3'd5:    begin w_mag = 5'd5; w_vlc_len = 4'd6; end
          default: begin w_mag = 5'd4; w_vlc_len = 4'd5; end
        endcase
      end else if (w_peek >= 9'd12) begin
        case (w_peek[4:0])
          5'd12:        begin w_mag = 5'd16; w_vlc_len = 4'd9; end
          5'd13:        begin w_mag = 5'd15; w_vlc_len = 4'd9; end
          5'd14:        begin w_mag = 5'd14; w_vlc_len = 4'd9; end
          5'd15:        begin w_mag = 5'd13; w_vlc_len = 4'd9; end
          5'd16:        begin w_mag = 5'd12; w_vlc_len = 4'd9; end
          5'd17:        begin w_mag = 5'd11; w_vlc_len = 4'd9; end
          5'd18, 5'd19: begin w_mag = 5'd10; w_vlc_len = 4'd8; end
          5'd20, 5'd21: begin w_mag = 5'd9;  w_vlc_len = 4'd8; end
          default:      begin w_mag = 5'd8;  w_vlc_len = 4'd8; end
        endcase
      end
      // Sign bit follows the leading '0' and the codeword body.
      if (w_vlc_len != 4'd0) begin
        w_neg      = w_win[4'd14 - w_vlc_len];
        w_code_len = w_vlc_len + 4'd2;
      end
    end
  end

  logic [31:0]        w_res_h;
  logic [31:0]        w_res_v;
  logic [13:0]        w_res_len_h;
  logic [13:0]        w_res_len_v;
  logic signed [31:0] w_h_new;
  logic signed [31:0] w_v_pre;
  logic signed [31:0] w_v_dec;
  logic signed [31:0] w_v_new;

  assign w_res_h     = f_residual(w_win, H_R_SIZE);
  assign w_res_v     = f_residual(w_win, V_R_SIZE);
  assign w_res_len_h = (H_R_SIZE != 0 && r_mag != 5'd0) ? 14'(H_R_SIZE) : 14'd0;
  assign w_res_len_v = (V_R_SIZE != 0 && r_mag != 5'd0) ? 14'(V_R_SIZE) : 14'd0;

  assign w_h_new = f_decode(r_pmv000, r_mag, r_neg, w_res_h, H_R_SIZE);
  // Field prediction with vertical scaling works on half-resolution vectors.
  assign w_v_pre = r_mvscale ? (r_pmv001 >>> 1) : r_pmv001;
  assign w_v_dec = f_decode(w_v_pre, r_mag, r_neg, w_res_v, V_R_SIZE);
  assign w_v_new = r_mvscale ? (w_v_dec <<< 1) : w_v_dec;

  // dmvector: '0' -> 0, '10' -> +1, '11' -> -1.
  logic signed [31:0] w_dmv_val;
  logic [13:0]        w_dmv_len;

  always_comb begin
    w_dmv_val = 32'sd0;
    w_dmv_len = 14'd0;
    if (r_dmv) begin
      if (!w_win[15]) begin
        w_dmv_len = 14'd1;
      end else begin
        w_dmv_len = 14'd2;
        w_dmv_val = w_win[14] ? -32'sd1 : 32'sd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_bfr          <= '0;
      r_dmv          <= 1'b0;
      r_mvscale      <= 1'b0;
      r_pmv000       <= '0;
      r_pmv001       <= '0;
      r_pmv010       <= '0;
      r_pmv011       <= '0;
      r_pmv110       <= '0;
      r_pmv111       <= '0;
      r_mvfs00       <= '0;
      r_mvfs01       <= '0;
      r_mvfs10       <= '0;
      r_mvfs11       <= '0;
      r_mag          <= '0;
      r_neg          <= 1'b0;
      r_dmv_h        <= '0;
      r_dmv_v        <= '0;
      out_PMV_0_0_0  <= '0;
      out_PMV_0_0_1  <= '0;
      out_PMV_0_1_0  <= '0;
      out_PMV_0_1_1  <= '0;
      out_PMV_1_0_0  <= '0;
      out_PMV_1_0_1  <= '0;
      out_PMV_1_1_0  <= '0;
      out_PMV_1_1_1  <= '0;
      out_mvfs_0_0   <= '0;
      out_mvfs_0_1   <= '0;
      out_mvfs_1_0   <= '0;
      out_mvfs_1_1   <= '0;
      out_dmvector_0 <= '0;
      out_dmvector_1 <= '0;
      done           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ptr     <= '0;
            r_bfr     <= in_bfr;
            r_dmv     <= |dmv;
            r_mvscale <= |mvscale;
            r_pmv000  <= in_PMV_0_0_0;
            r_pmv001  <= in_PMV_0_0_1;
            r_pmv010  <= in_PMV_0_1_0;
            r_pmv011  <= in_PMV_0_1_1;
            r_pmv110  <= in_PMV_1_1_0;
            r_pmv111  <= in_PMV_1_1_1;
            r_mvfs00  <= in_mvfs_0_0;
            r_mvfs01  <= in_mvfs_0_1;
            r_mvfs10  <= in_mvfs_1_0;
            r_mvfs11  <= in_mvfs_1_1;
            r_state   <= S_FSEL;
          end
        end
        S_FSEL: begin
          if (!r_dmv) begin
            r_mvfs00 <= {31'd0, w_win[15]};
            r_mvfs10 <= {31'd0, w_win[15]};
            r_ptr    <= r_ptr + 14'd1;
          end
          r_state <= S_HCODE;
        end
        S_HCODE: begin
          r_mag   <= w_mag;
          r_neg   <= w_neg;
          r_ptr   <= r_ptr + 14'(w_code_len);
          r_state <= S_HRES;
        end
        S_HRES: begin
          r_pmv000 <= w_h_new;
          r_ptr    <= r_ptr + w_res_len_h;
          r_state  <= S_HDMV;
        end
        S_HDMV: begin
          r_dmv_h <= w_dmv_val;
          r_ptr   <= r_ptr + w_dmv_len;
          r_state <= S_VCODE;
        end
        S_VCODE: begin
          r_mag   <= w_mag;
          r_neg   <= w_neg;
          r_ptr   <= r_ptr + 14'(w_code_len);
          r_state <= S_VRES;
        end
        S_VRES: begin
          r_pmv001 <= w_v_new;
          r_ptr    <= r_ptr + w_res_len_v;
          r_state  <= S_VDMV;
        end
        S_VDMV: begin
          r_dmv_v <= w_dmv_val;
          r_ptr   <= r_ptr + w_dmv_len;
          r_state <= S_DONE;
        end
        S_DONE: begin
          out_PMV_0_0_0  <= r_pmv000;
          out_PMV_0_0_1  <= r_pmv001;
          out_PMV_1_0_0  <= r_pmv000;
          out_PMV_1_0_1  <= r_pmv001;
          out_PMV_0_1_0  <= r_pmv010;
          out_PMV_0_1_1  <= r_pmv011;
          out_PMV_1_1_0  <= r_pmv110;
          out_PMV_1_1_1  <= r_pmv111;
          out_mvfs_0_0   <= r_mvfs00;
          out_mvfs_0_1   <= r_mvfs01;
          out_mvfs_1_0   <= r_mvfs10;
          out_mvfs_1_1   <= r_mvfs11;
          out_dmvector_0 <= r_dmv_h;
          out_dmvector_1 <= r_dmv_v;
          done           <= 1'b1;
          r_state        <= S_HOLD;
        end
        S_HOLD: begin
          r_state <= S_HOLD;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_vectors_decoder.sv
module tb_motion_vectors_decoder;

  localparam int R_H = 8;
  localparam int R_V = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic signed [31:0] p000, p001, p010, p011, p100, p101, p110, p111;
  logic [31:0] fs00, fs01, fs10, fs11;
  logic [31:0] dmv, mvscale;
  logic [16383:0] bfr;

  logic signed [31:0] o000, o001, o010, o011, o100, o101, o110, o111;
  logic [31:0] ofs00, ofs01, ofs10, ofs11;
  logic signed [31:0] odm0, odm1;
  logic done;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  motion_vectors_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_PMV_0_0_0(p000), .in_PMV_0_0_1(p001), .in_PMV_0_1_0(p010), .in_PMV_0_1_1(p011),
    .in_PMV_1_0_0(p100), .in_PMV_1_0_1(p101), .in_PMV_1_1_0(p110), .in_PMV_1_1_1(p111),
    .in_mvfs_0_0(fs00), .in_mvfs_0_1(fs01), .in_mvfs_1_0(fs10), .in_mvfs_1_1(fs11),
    .dmv(dmv), .mvscale(mvscale), .in_bfr(bfr),
    .out_PMV_0_0_0(o000), .out_PMV_0_0_1(o001), .out_PMV_0_1_0(o010), .out_PMV_0_1_1(o011),
    .out_PMV_1_0_0(o100), .out_PMV_1_0_1(o101), .out_PMV_1_1_0(o110), .out_PMV_1_1_1(o111),
    .out_mvfs_0_0(ofs00), .out_mvfs_0_1(ofs01), .out_mvfs_1_0(ofs10), .out_mvfs_1_1(ofs11),
    .out_dmvector_0(odm0), .out_dmvector_1(odm1), .done(done)
  );

  // motion_code codewords (bits after the leading '0', sign bit excluded),
  // entry k is magnitude k+1.
  int cw_val [16] = '{1, 1, 1, 3, 5, 4, 3, 11, 10, 9, 17, 16, 15, 14, 13, 12};
  int cw_len [16] = '{1, 2, 3, 5, 6, 6, 6, 8, 8, 8, 9, 9, 9, 9, 9, 9};

  typedef struct {
    logic [31:0] top;
    logic [31:0] dmv;
    logic [31:0] mvs;
    int p0;
    int p1;
    int f00;
    int f10;
    int eh;
    int ev;
    int ef00;
    int ef10;
    int edh;
    int edv;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name,
                  $signed(act), act, $signed(exp), exp);
  endtask

  // ---------------- reference model ----------------
  int m_ptr;

  function automatic logic mbit(input int p);
    return bfr[16383 - p];
  endfunction

  task automatic m_code(output int code);
    logic ok;
    logic hit;
    code = 0;
    if (mbit(m_ptr)) begin
      m_ptr++;
      return;
    end
    m_ptr++;
    hit = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!hit) begin
        ok = 1'b1;
        for (int i = 0; i < cw_len[k]; i++)
          if (mbit(m_ptr + i) != cw_val[k][cw_len[k] - 1 - i]) ok = 1'b0;
        if (ok) begin
          hit = 1'b1;
          m_ptr += cw_len[k];
          code = mbit(m_ptr) ? -(k + 1) : (k + 1);
          m_ptr++;
        end
      end
    end
  endtask

  task automatic m_res(input int rsize, input int code, output int res);
    res = 0;
    if (rsize != 0 && code != 0)
      for (int i = 0; i < rsize; i++) begin
        res = res * 2 + int'(mbit(m_ptr));
        m_ptr++;
      end
  endtask

  function automatic int m_apply(input int vec, input int code, input int res, input int rsize);
    int lim;
    int v;
    lim = 16 << rsize;
    v = vec;
    if (code > 0) begin
      v = v + ((code - 1) << rsize) + res + 1;
      if (v >= lim) v = v - 2 * lim;
    end else if (code < 0) begin
      v = v - (((-code) - 1) << rsize) - res - 1;
      if (v < -lim) v = v + 2 * lim;
    end
    return v;
  endfunction

  task automatic m_dmv(output int d);
    d = 0;
    if (dmv != 0) begin
      if (mbit(m_ptr)) begin
        d = mbit(m_ptr + 1) ? -1 : 1;
        m_ptr += 2;
      end else begin
        m_ptr += 1;
      end
    end
  endtask

  task automatic run_model(output int eh, output int ev, output int ef00, output int ef10,
                           output int edh, output int edv);
    int c;
    int r;
    int v;
    m_ptr = 0;
    ef00 = int'(fs00);
    ef10 = int'(fs10);
    if (dmv == 0) begin
      ef00 = int'(mbit(m_ptr));
      ef10 = ef00;
      m_ptr++;
    end
    m_code(c);
    m_res(R_H, c, r);
    eh = m_apply(p000, c, r, R_H);
    m_dmv(edh);
    m_code(c);
    m_res(R_V, c, r);
    v = p001;
    if (mvscale != 0) v = v >>> 1;
    v = m_apply(v, c, r, R_V);
    if (mvscale != 0) v = v * 2;
    ev = v;
    m_dmv(edv);
  endtask

  // ---------------- stimulus helpers ----------------
  logic q [$];

  task automatic push_code(input int mag, input logic neg);
    if (mag == 0) begin
      q.push_back(1'b1);
    end else begin
      q.push_back(1'b0);
      for (int i = cw_len[mag - 1] - 1; i >= 0; i--) q.push_back(cw_val[mag - 1][i]);
      q.push_back(neg);
      for (int i = 0; i < 8; i++) q.push_back(1'($urandom_range(1)));
    end
  endtask

  task automatic push_dmv();
    int d;
    d = $urandom_range(2);
    if (d == 0) q.push_back(1'b0);
    else begin
      q.push_back(1'b1);
      q.push_back(1'($urandom_range(1)));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start_and_wait();
    logic early;
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    early = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
      if (done) early = 1'b1;
    end
    check("done_before_edge8", 32'(early), 32'd0);
    @(posedge clk);
    #1;
    check("done_at_edge8", 32'(done), 32'd1);
  endtask

  task automatic check_all(input int eh, input int ev, input int ef00, input int ef10,
                           input int edh, input int edv);
    check("PMV000", o000, eh);
    check("PMV001", o001, ev);
    check("PMV100", o100, eh);
    check("PMV101", o101, ev);
    check("PMV010", o010, p010);
    check("PMV011", o011, p011);
    check("PMV110", o110, p110);
    check("PMV111", o111, p111);
    check("mvfs00", ofs00, ef00);
    check("mvfs10", ofs10, ef10);
    check("mvfs01", ofs01, fs01);
    check("mvfs11", ofs11, fs11);
    check("dmvector0", odm0, edh);
    check("dmvector1", odm1, edv);
  endtask

  task automatic load_vec(input vec_t t);
    bfr = '0;
    bfr[16383 -: 32] = t.top;
    dmv = t.dmv;
    mvscale = t.mvs;
    p000 = t.p0;
    p001 = t.p1;
    fs00 = t.f00;
    fs10 = t.f10;
    p010 = 11; p011 = -22; p100 = 999; p101 = -999; p110 = 33; p111 = -44;
    fs01 = 200; fs11 = 240;
  endtask

  initial begin
    int eh, ev, ef00, ef10, edh, edv;
    logic [31:0] stuck;

    tbl[0] = '{32'h0000_0000, 32'd0, 32'd1, 45, 207, 5, 7, 45, 206, 0, 0, 0, 0};
    tbl[1] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 45, 207, 232, 32, 45, 207, 1, 1, 0, 0};
    tbl[2] = '{32'h20F8_0000, 32'd0, 32'd0, 45, 207, 232, 32, 61, 207, 0, 0, 0, 0};
    tbl[3] = '{32'hB0F8_0000, 32'd0, 32'd0, -4090, 207, 232, 32, 4086, 207, 1, 1, 0, 0};
    tbl[4] = '{32'hF000_0000, 32'd1, 32'd0, 45, 207, 232, 32, 45, 207, 232, 32, -1, 0};
    tbl[5] = '{32'h0180_0800, 32'd0, 32'd0, 45, 207, 232, 32, 3886, 207, 0, 0, 0, 0};
    tbl[6] = '{32'hC60A_0000, 32'd3, 32'd1, 45, -300, 232, 32, 45, -824, 232, 32, 1, 0};

    rst = 1'b0;
    in_valid = 1'b0;
    load_vec(tbl[0]);
    #2;
    check("reset_done", 32'(done), 32'd0);
    check("reset_PMV001", o001, 32'd0);
    check("reset_mvfs01", ofs01, 32'd0);
    check("reset_dmvector0", odm0, 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      load_vec(tbl[i]);
      start_and_wait();
      check_all(tbl[i].eh, tbl[i].ev, tbl[i].ef00, tbl[i].ef10, tbl[i].edh, tbl[i].edv);
    end

    // done is sticky and a new request is ignored
    @(negedge clk);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check("sticky_done", 32'(done), 32'd1);
    check("sticky_PMV001", o001, -32'sd824);

    // async clear between clock edges
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_done", 32'(done), 32'd0);
    check("async_PMV000", o000, 32'd0);
    check("async_mvfs10", ofs10, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // reset in the middle of a parse aborts it
    load_vec(tbl[0]);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("midparse_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stuck = 32'd0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) stuck = 32'd1;
    end
    check("abort_stays_idle", stuck, 32'd0);
    start_and_wait();
    check_all(45, 206, 0, 0, 0, 0);

    // randomized runs against the model
    for (int it = 0; it < 120; it++) begin
      do_reset();
      for (int w = 0; w < 512; w++) bfr[w * 32 +: 32] = $urandom();
      dmv     = ($urandom_range(1) == 1) ? 32'($urandom_range(1, 7)) : 32'd0;
      mvscale = ($urandom_range(1) == 1) ? 32'($urandom_range(1, 7)) : 32'd0;
      p000 = int'($urandom_range(8191)) - 4096;
      p001 = int'($urandom_range(8191)) - 4096;
      p010 = $urandom(); p011 = $urandom(); p100 = $urandom(); p101 = $urandom();
      p110 = $urandom(); p111 = $urandom();
      fs00 = $urandom_range(255); fs01 = $urandom_range(255);
      fs10 = $urandom_range(255); fs11 = $urandom_range(255);
      if (it % 2 == 0) begin
        q.delete();
        if (dmv == 0) q.push_back(1'($urandom_range(1)));
        push_code($urandom_range(16), 1'($urandom_range(1)));
        if (dmv != 0) push_dmv();
        push_code($urandom_range(16), 1'($urandom_range(1)));
        if (dmv != 0) push_dmv();
        for (int i = 0; i < q.size(); i++) bfr[16383 - i] = q[i];
      end
      run_model(eh, ev, ef00, ef10, edh, edv);
      start_and_wait();
      check_all(eh, ev, ef00, ef10, edh, edv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
